// File: rtl/id_hazard_ctrl.sv
`default_nettype none
// +-----------------------------------------------------------------------------+
// | id_hazard_ctrl : ID-stage load-use stall / branch flush control.            |
// |   Optional HAZ_PERF_CNT_EN adds saturating stall/flush counters.            |
// | Revision: 1.0                                                               |
// +-----------------------------------------------------------------------------+
module id_hazard_ctrl #(
  parameter int LOAD_STALL_CYCLES = 1,
  parameter int PERF_W            = 32
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic [31:0]       ifid_instr_i,
  input  logic              idex_memread_i,
  input  logic [4:0]        idex_rt_i,
  input  logic              branch_taken_i,
  output logic              pc_write_o,
  output logic              ifid_write_o,
  output logic              idex_bubble_o,
  output logic              ifid_flush_o,
  output logic              stalling_o,
  output logic [PERF_W-1:0] stall_cnt_o,
  output logic [PERF_W-1:0] flush_cnt_o
);

  localparam logic [5:0] c_OP_RTYPE = 6'h00;
  localparam logic [5:0] c_OP_J     = 6'h02;
  localparam logic [5:0] c_OP_BEQ   = 6'h04;
  localparam logic [5:0] c_OP_SW    = 6'h2B;
  localparam logic [2:0] c_STALL_INIT = 3'(LOAD_STALL_CYCLES - 1);
  localparam bit         c_MULTI      = (LOAD_STALL_CYCLES > 1);

  typedef enum logic [0:0] {
    S_RUN   = 1'b0,
    S_STALL = 1'b1
  } state_t;

  if ((LOAD_STALL_CYCLES < 1) || (LOAD_STALL_CYCLES > 7)) begin : g_bad_cfg
    $error("id_hazard_ctrl: LOAD_STALL_CYCLES=%0d outside 1..7", LOAD_STALL_CYCLES);
  end

  state_t     r_state;
  state_t     w_state_nxt;
  logic [2:0] r_cnt;
  logic [2:0] w_cnt_nxt;

  logic [5:0] w_opcode;
  logic [4:0] w_rs;
  logic [4:0] w_rt;
  logic       w_uses_rs;
  logic       w_uses_rt;
  logic       w_hazard;
  logic [15:0] w_unused_imm;

  assign w_opcode     = ifid_instr_i[31:26];
  assign w_rs         = ifid_instr_i[25:21];
  assign w_rt         = ifid_instr_i[20:16];
  assign w_unused_imm = ifid_instr_i[15:0];

  assign w_uses_rs = (w_opcode != c_OP_J);
  assign w_uses_rt = (w_opcode == c_OP_RTYPE) || (w_opcode == c_OP_SW) ||
                     (w_opcode == c_OP_BEQ);
  // $0 is hard-wired, so a load targeting it can never create a dependency
  assign w_hazard  = idex_memread_i && (idex_rt_i != 5'd0) &&
                     ((w_uses_rs && (w_rs == idex_rt_i)) ||
                      (w_uses_rt && (w_rt == idex_rt_i)));

  always_comb begin
    w_state_nxt   = r_state;
    w_cnt_nxt     = r_cnt;
    pc_write_o    = 1'b1;
    ifid_write_o  = 1'b1;
    idex_bubble_o = 1'b0;
    ifid_flush_o  = 1'b0;
    stalling_o    = 1'b0;
    if (!rst_i) begin
      case (r_state)
        S_RUN: begin
          // Stall beats flush: the branch compared stale operands this cycle
          if (w_hazard) begin
            pc_write_o    = 1'b0;
            ifid_write_o  = 1'b0;
            idex_bubble_o = 1'b1;
            if (c_MULTI) begin
              w_state_nxt = S_STALL;
              w_cnt_nxt   = c_STALL_INIT;
            end
          end else if (branch_taken_i) begin
            ifid_flush_o = 1'b1;
          end
        end
        S_STALL: begin
          pc_write_o    = 1'b0;
          ifid_write_o  = 1'b0;
          idex_bubble_o = 1'b1;
          stalling_o    = 1'b1;
          w_cnt_nxt     = r_cnt - 3'd1;
          if (r_cnt <= 3'd1) begin
            w_state_nxt = S_RUN;
          end
        end
        default: begin
          w_state_nxt = S_RUN;
          w_cnt_nxt   = 3'd0;
        end
      endcase
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_state <= S_RUN;
      r_cnt   <= 3'd0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
    end
  end

`ifdef HAZ_PERF_CNT_EN
  logic [PERF_W-1:0] r_stall_cnt;
  logic [PERF_W-1:0] r_flush_cnt;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_stall_cnt <= '0;
      r_flush_cnt <= '0;
    end else begin
      if (idex_bubble_o && (r_stall_cnt != '1)) begin
        r_stall_cnt <= r_stall_cnt + PERF_W'(1);
      end
      if (ifid_flush_o && (r_flush_cnt != '1)) begin
        r_flush_cnt <= r_flush_cnt + PERF_W'(1);
      end
    end
  end

  assign stall_cnt_o = r_stall_cnt;
  assign flush_cnt_o = r_flush_cnt;
`else
  assign stall_cnt_o = '0;
  assign flush_cnt_o = '0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_id_hazard_ctrl.sv
`default_nettype none
// Bench for id_hazard_ctrl: three instances (1/3/4 stall cycles) on shared stimulus,
// checked each cycle against a bubble-budget model plus literal expectations.
module tb_id_hazard_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] instr;
  logic        memread;
  logic [4:0]  ldrt;
  logic        br;

  logic        pcw [3];
  logic        ifw [3];
  logic        bub [3];
  logic        fls [3];
  logic        stl [3];
  logic [1:0]  sc0, fc0;
  logic [31:0] sc1, fc1, sc2, fc2;
  logic [31:0] sca [3];
  logic [31:0] fca [3];

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  id_hazard_ctrl #(.LOAD_STALL_CYCLES(1), .PERF_W(2)) u_d1 (
    .clk_i(clk), .rst_i(rst), .ifid_instr_i(instr), .idex_memread_i(memread),
    .idex_rt_i(ldrt), .branch_taken_i(br), .pc_write_o(pcw[0]), .ifid_write_o(ifw[0]),
    .idex_bubble_o(bub[0]), .ifid_flush_o(fls[0]), .stalling_o(stl[0]),
    .stall_cnt_o(sc0), .flush_cnt_o(fc0));
  id_hazard_ctrl #(.LOAD_STALL_CYCLES(3), .PERF_W(32)) u_d3 (
    .clk_i(clk), .rst_i(rst), .ifid_instr_i(instr), .idex_memread_i(memread),
    .idex_rt_i(ldrt), .branch_taken_i(br), .pc_write_o(pcw[1]), .ifid_write_o(ifw[1]),
    .idex_bubble_o(bub[1]), .ifid_flush_o(fls[1]), .stalling_o(stl[1]),
    .stall_cnt_o(sc1), .flush_cnt_o(fc1));
  id_hazard_ctrl #(.LOAD_STALL_CYCLES(4), .PERF_W(32)) u_d4 (
    .clk_i(clk), .rst_i(rst), .ifid_instr_i(instr), .idex_memread_i(memread),
    .idex_rt_i(ldrt), .branch_taken_i(br), .pc_write_o(pcw[2]), .ifid_write_o(ifw[2]),
    .idex_bubble_o(bub[2]), .ifid_flush_o(fls[2]), .stalling_o(stl[2]),
    .stall_cnt_o(sc2), .flush_cnt_o(fc2));

  assign sca[0] = {30'd0, sc0};
  assign fca[0] = {30'd0, fc0};
  assign sca[1] = sc1;
  assign fca[1] = fc1;
  assign sca[2] = sc2;
  assign fca[2] = fc2;

  task automatic chk(input string name, input int k, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s inst%0d: got %0h expected %0h at %0t", name, k, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  int    nstall [3] = '{1, 3, 4};
  int    satmax [3] = '{3, 32'hFFFF_FFFF, 32'hFFFF_FFFF};
  int    rem    [3] = '{0, 0, 0};
  longint msc   [3] = '{0, 0, 0};
  longint mfc   [3] = '{0, 0, 0};
  bit    started = 1'b0;

  function automatic bit hazard(input logic [31:0] ins, input logic mr, input logic [4:0] rt);
    logic [5:0] op;
    bit urs, urt;
    op  = ins[31:26];
    urs = (op != 6'h02);
    urt = (op == 6'h00) || (op == 6'h2B) || (op == 6'h04);
    return mr && (rt != 5'd0) &&
           ((urs && ins[25:21] == rt) || (urt && ins[20:16] == rt));
  endfunction

  // A hazard buys N bubbles: one now, N-1 more owed afterwards regardless of inputs.
  function automatic bit exp_bubble(input int k);
    return !rst && (rem[k] > 0 || hazard(instr, memread, ldrt));
  endfunction

  function automatic bit exp_flush(input int k);
    return !rst && !exp_bubble(k) && br;
  endfunction

  always @(posedge clk) begin
    for (int k = 0; k < 3; k++) begin
      if (rst) begin
        rem[k] = 0;
        msc[k] = 0;
        mfc[k] = 0;
      end else begin
        if (exp_bubble(k) && msc[k] < longint'(unsigned'(satmax[k]))) msc[k]++;
        if (exp_flush(k) && mfc[k] < longint'(unsigned'(satmax[k]))) mfc[k]++;
        if (rem[k] > 0) rem[k]--;
        else if (hazard(instr, memread, ldrt)) rem[k] = nstall[k] - 1;
      end
    end
    started = 1'b1;
  end

  always @(negedge clk) begin
    if (started) begin
      for (int k = 0; k < 3; k++) begin
        chk("pc_write", k, 32'(pcw[k]), 32'(!exp_bubble(k)));
        chk("ifid_write", k, 32'(ifw[k]), 32'(!exp_bubble(k)));
        chk("bubble", k, 32'(bub[k]), 32'(exp_bubble(k)));
        chk("flush", k, 32'(fls[k]), 32'(exp_flush(k)));
        chk("stalling", k, 32'(stl[k]), 32'(!rst && rem[k] > 0));
`ifdef HAZ_PERF_CNT_EN
        chk("stall_cnt", k, sca[k], 32'(msc[k]));
        chk("flush_cnt", k, fca[k], 32'(mfc[k]));
`else
        chk("stall_cnt", k, sca[k], 32'd0);
        chk("flush_cnt", k, fca[k], 32'd0);
`endif
      end
    end
  end

  // ---------------- directed stimulus ----------------
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    memread = 1'b0; ldrt = 5'd0; instr = 32'd0; br = 1'b0;
    repeat (n) step();
  endtask

  int nb3, ns3, nb4;

  initial begin
    rst = 1'b1; instr = 32'd0; memread = 1'b0; ldrt = 5'd0; br = 1'b0;
    step();
    @(negedge clk);
    chk("rst_pc_write", 1, 32'(pcw[1]), 32'd1);
    chk("rst_bubble", 1, 32'(bub[1]), 32'd0);
    step();
    rst = 1'b0;
    @(negedge clk);
    chk("rst_stall_cnt", 1, sca[1], 32'd0);
    chk("rst_stalling", 2, 32'(stl[2]), 32'd0);

    // add $3,$2,$4 after a load to $2
    step();
    memread = 1'b1; ldrt = 5'd2; instr = 32'h0044_1820;
    @(negedge clk);
    chk("lu_pc_write", 0, 32'(pcw[0]), 32'd0);
    chk("lu_ifid_write", 0, 32'(ifw[0]), 32'd0);
    chk("lu_bubble", 0, 32'(bub[0]), 32'd1);
    chk("lu_stalling", 0, 32'(stl[0]), 32'd0);
    step();
    memread = 1'b0; instr = 32'd0;
    @(negedge clk);
    chk("lu_after_pc", 0, 32'(pcw[0]), 32'd1);
    chk("lu_after_bub", 0, 32'(bub[0]), 32'd0);
    chk("lu_after_stl3", 1, 32'(stl[1]), 32'd1);
    idle(5);

    // rt=0 load and addi with only an rt match: no stall
    memread = 1'b1; ldrt = 5'd0; instr = 32'h0000_1820;
    @(negedge clk);
    chk("rt0_pc_write", 1, 32'(pcw[1]), 32'd1);
    step();
    memread = 1'b1; ldrt = 5'd3; instr = 32'h20A3_0002;
    @(negedge clk);
    chk("addi_pc_write", 1, 32'(pcw[1]), 32'd1);
    chk("addi_bubble", 2, 32'(bub[2]), 32'd0);
    idle(1);

    // sw $2,0($6) vs load $2: 3 / 4 bubble cycles
    memread = 1'b1; ldrt = 5'd2; instr = 32'hACC2_0000;
    nb3 = 0; ns3 = 0; nb4 = 0;
    for (int i = 0; i < 7; i++) begin
      @(negedge clk);
      nb3 += int'(bub[1]); ns3 += int'(stl[1]); nb4 += int'(bub[2]);
      step();
      memread = 1'b0;
    end
    chk("sw_bubbles3", 1, 32'(nb3), 32'd3);
    chk("sw_stalling3", 1, 32'(ns3), 32'd2);
    chk("sw_bubbles4", 2, 32'(nb4), 32'd4);

    // single-cycle branch pulse
    idle(1);
    br = 1'b1;
    @(negedge clk);
    chk("br_flush", 0, 32'(fls[0]), 32'd1);
    chk("br_pc_write", 0, 32'(pcw[0]), 32'd1);
    step();
    br = 1'b0;
    @(negedge clk);
    chk("br_flush_off", 0, 32'(fls[0]), 32'd0);

    // hazard and branch together, branch held one more cycle
    step();
    memread = 1'b1; ldrt = 5'd2; instr = 32'h0044_1820; br = 1'b1;
    @(negedge clk);
    chk("hb_flush", 0, 32'(fls[0]), 32'd0);
    chk("hb_bubble", 0, 32'(bub[0]), 32'd1);
    step();
    memread = 1'b0;
    @(negedge clk);
    chk("hb_flush_next", 0, 32'(fls[0]), 32'd1);
    chk("hb_flush_stall", 1, 32'(fls[1]), 32'd0);
    idle(6);

    // reset during 4-cycle stall
    memread = 1'b1; ldrt = 5'd2; instr = 32'hACC2_0000;
    step();
    memread = 1'b0;
    step();
    rst = 1'b1;
    @(negedge clk);
    chk("mid_rst_pc", 2, 32'(pcw[2]), 32'd1);
    step();
    rst = 1'b0;
    @(negedge clk);
    chk("post_rst_stl", 2, 32'(stl[2]), 32'd0);
    chk("post_rst_pc", 2, 32'(pcw[2]), 32'd1);
    chk("post_rst_bub", 2, 32'(bub[2]), 32'd0);

    // counters: one sw stall plus two flushes, then saturation of the 2-bit instance
    step();
    memread = 1'b1; ldrt = 5'd2; instr = 32'hACC2_0000;
    step();
    idle(5);
    br = 1'b1; step(); br = 1'b0; step();
    br = 1'b1; step(); br = 1'b0;
    @(negedge clk);
`ifdef HAZ_PERF_CNT_EN
    chk("perf_stall3", 1, sca[1], 32'd3);
    chk("perf_flush3", 1, fca[1], 32'd2);
    chk("perf_stall4", 2, sca[2], 32'd4);
    chk("perf_stall1", 0, sca[0], 32'd1);
`else
    chk("perf_stall3", 1, sca[1], 32'd0);
    chk("perf_flush3", 1, fca[1], 32'd0);
`endif
    for (int i = 0; i < 3; i++) begin
      step(); br = 1'b1; step(); br = 1'b0;
    end
    @(negedge clk);
`ifdef HAZ_PERF_CNT_EN
    chk("perf_sat_flush", 0, fca[0], 32'd3);
    chk("perf_flush5", 1, fca[1], 32'd5);
`else
    chk("perf_sat_flush", 0, fca[0], 32'd0);
`endif
    idle(2);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire
